// File: rtl/mem_req_arbiter_if.sv
// Bundle of fetch, load/store and downstream bus signals
// seen by the memory request arbiter.
interface mem_req_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [2:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        bus_req;
    logic        bus_wr;
    logic [2:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    logic        busy;

    modport master (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb,
        input  data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output bus_req, bus_wr, bus_size, bus_wstrb,
        output bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output busy
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb,
        output data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  bus_req, bus_wr, bus_size, bus_wstrb,
        input  bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Two-master (fetch, load/store) to one-bus arbiter with
// starvation guard; one outstanding transaction at a time.
module mem_req_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_p,
    mem_req_arbiter_if.master  m_if
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_owner;
    logic [3:0]  r_starve_cnt;
    logic        r_wr;
    logic [2:0]  r_size;
    logic [3:0]  r_wstrb;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic w_any_req;
    logic w_inst_win;
    logic w_addr_ack;
    logic w_data_ack;

    // r_owner: 1 = fetch owns the bus, 0 = load/store
    assign w_any_req  = m_if.inst_req | m_if.data_req;
    assign w_inst_win = m_if.inst_req &
                        (~m_if.data_req | (r_starve_cnt == LIMIT));

    assign w_addr_ack = (r_state == ADDR) & m_if.bus_addr_ok;
    assign w_data_ack = (w_addr_ack & m_if.bus_data_ok) |
                        ((r_state == DATA) & m_if.bus_data_ok);

    // Arbitrate in IDLE, latch the winner, then walk ADDR/DATA
    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_starve_cnt <= 4'd0;
            r_wr         <= 1'b0;
            r_size       <= 3'd0;
            r_wstrb      <= 4'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state <= ADDR;
                        r_owner <= w_inst_win;
                        if (w_inst_win) begin
                            r_wr         <= 1'b0;
                            r_size       <= 3'd4;
                            r_wstrb      <= 4'd0;
                            r_addr       <= m_if.inst_addr;
                            r_wdata      <= 32'd0;
                            r_starve_cnt <= 4'd0;
                        end else begin
                            r_wr    <= m_if.data_wr;
                            r_size  <= m_if.data_size;
                            r_wstrb <= m_if.data_wstrb;
                            r_addr  <= m_if.data_addr;
                            r_wdata <= m_if.data_wdata;
                            if (m_if.inst_req &&
                                r_starve_cnt != LIMIT)
                                r_starve_cnt <= r_starve_cnt + 4'd1;
                        end
                    end
                end
                ADDR: begin
                    if (m_if.bus_addr_ok)
                        r_state <= m_if.bus_data_ok ? IDLE : DATA;
                end
                DATA: begin
                    if (m_if.bus_data_ok)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_if.bus_req   = (r_state == ADDR);
    assign m_if.bus_wr    = r_wr;
    assign m_if.bus_size  = r_size;
    assign m_if.bus_wstrb = r_wstrb;
    assign m_if.bus_addr  = r_addr;
    assign m_if.bus_wdata = r_wdata;
    assign m_if.busy      = (r_state != IDLE);

    assign m_if.inst_addr_ok = w_addr_ack & r_owner;
    assign m_if.data_addr_ok = w_addr_ack & ~r_owner;
    assign m_if.inst_data_ok = w_data_ack & r_owner;
    assign m_if.data_data_ok = w_data_ack & ~r_owner;

    assign m_if.inst_rdata = m_if.bus_rdata;
    assign m_if.data_rdata = m_if.bus_rdata;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed-vector bench for mem_req_arbiter.
// Each task drives one scenario and checks inline.
module tb_mem_req_arbiter;

    logic clk;
    logic rst_p;
    int   errors;
    int   checks;

    mem_req_arbiter_if ifc ();

    mem_req_arbiter #(
        .STARVE_LIMIT(4)
    ) dut (
        .clk  (clk),
        .rst_p(rst_p),
        .m_if (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifc.inst_req    = 1'b0;
        ifc.inst_addr   = 32'd0;
        ifc.data_req    = 1'b0;
        ifc.data_wr     = 1'b0;
        ifc.data_size   = 3'd0;
        ifc.data_wstrb  = 4'd0;
        ifc.data_addr   = 32'd0;
        ifc.data_wdata  = 32'd0;
        ifc.bus_addr_ok = 1'b0;
        ifc.bus_data_ok = 1'b0;
        ifc.bus_rdata   = 32'd0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_p = 1'b1;
        tick();
        tick();
        rst_p = 1'b0;
        ifc.bus_data_ok = 1'b1;
        #1;
        checks++;
        if ({ifc.bus_req, ifc.busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_req_busy: got %b want 00",
                     {ifc.bus_req, ifc.busy});
        end
        checks++;
        if ({ifc.inst_addr_ok, ifc.inst_data_ok,
             ifc.data_addr_ok, ifc.data_data_ok} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_oks: got %b want 0000",
                     {ifc.inst_addr_ok, ifc.inst_data_ok,
                      ifc.data_addr_ok, ifc.data_data_ok});
        end
        checks++;
        if ({ifc.bus_addr, ifc.bus_wdata} !== 64'd0) begin
            errors++;
            $display("FAIL reset_fields: got %h want 0",
                     {ifc.bus_addr, ifc.bus_wdata});
        end
        tick();
        ifc.bus_data_ok = 1'b0;
        #1;
        checks++;
        if (ifc.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores_data_ok: busy=%b want 0",
                     ifc.busy);
        end
    endtask

    task automatic test_inst_fetch();
        ifc.inst_req  = 1'b1;
        ifc.inst_addr = 32'hBFC0_0000;
        #1;
        checks++;
        if (ifc.busy !== 1'b0) begin
            errors++;
            $display("FAIL fetch_idle_busy: got %b want 0", ifc.busy);
        end
        tick();
        checks++;
        if ({ifc.bus_req, ifc.bus_wr, ifc.bus_size} !== 5'b1_0_100) begin
            errors++;
            $display("FAIL fetch_req_wr_size: got %b want 10100",
                     {ifc.bus_req, ifc.bus_wr, ifc.bus_size});
        end
        checks++;
        if (ifc.bus_addr !== 32'hBFC0_0000) begin
            errors++;
            $display("FAIL fetch_addr: got %h want bfc00000",
                     ifc.bus_addr);
        end
        checks++;
        if (ifc.inst_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL fetch_early_addr_ok: got %b want 0",
                     ifc.inst_addr_ok);
        end
        tick();
        ifc.bus_addr_ok = 1'b1;
        #1;
        checks++;
        if ({ifc.inst_addr_ok, ifc.data_addr_ok,
             ifc.inst_data_ok} !== 3'b100) begin
            errors++;
            $display("FAIL fetch_addr_ok: got %b want 100",
                     {ifc.inst_addr_ok, ifc.data_addr_ok,
                      ifc.inst_data_ok});
        end
        tick();
        ifc.inst_req    = 1'b0;
        ifc.bus_addr_ok = 1'b0;
        ifc.bus_data_ok = 1'b1;
        ifc.bus_rdata   = 32'h3C1D_0000;
        #1;
        checks++;
        if ({ifc.bus_req, ifc.inst_addr_ok, ifc.inst_data_ok,
             ifc.data_data_ok} !== 4'b0010) begin
            errors++;
            $display("FAIL fetch_data_ok: got %b want 0010",
                     {ifc.bus_req, ifc.inst_addr_ok,
                      ifc.inst_data_ok, ifc.data_data_ok});
        end
        checks++;
        if (ifc.inst_rdata !== 32'h3C1D_0000) begin
            errors++;
            $display("FAIL fetch_rdata: got %h want 3c1d0000",
                     ifc.inst_rdata);
        end
        tick();
        ifc.bus_data_ok = 1'b0;
        #1;
        checks++;
        if ({ifc.busy, ifc.inst_data_ok} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_done: got %b want 00",
                     {ifc.busy, ifc.inst_data_ok});
        end
    endtask

    task automatic test_contention();
        ifc.inst_req   = 1'b1;
        ifc.inst_addr  = 32'h0000_1000;
        ifc.data_req   = 1'b1;
        ifc.data_wr    = 1'b1;
        ifc.data_size  = 3'd1;
        ifc.data_wstrb = 4'b1000;
        ifc.data_addr  = 32'h8000_1003;
        ifc.data_wdata = 32'hAB00_0000;
        tick();
        ifc.bus_addr_ok = 1'b1;
        #1;
        checks++;
        if ({ifc.bus_wr, ifc.bus_size, ifc.bus_wstrb} !== 8'b1_001_1000) begin
            errors++;
            $display("FAIL store_wr_size_strb: got %b want 10011000",
                     {ifc.bus_wr, ifc.bus_size, ifc.bus_wstrb});
        end
        checks++;
        if ({ifc.bus_addr, ifc.bus_wdata} !== 64'h80001003_AB000000) begin
            errors++;
            $display("FAIL store_addr_wdata: got %h want 80001003ab000000",
                     {ifc.bus_addr, ifc.bus_wdata});
        end
        checks++;
        if ({ifc.data_addr_ok, ifc.inst_addr_ok} !== 2'b10) begin
            errors++;
            $display("FAIL store_addr_ok: got %b want 10",
                     {ifc.data_addr_ok, ifc.inst_addr_ok});
        end
        tick();
        ifc.data_req    = 1'b0;
        ifc.bus_addr_ok = 1'b0;
        ifc.bus_data_ok = 1'b1;
        #1;
        checks++;
        if ({ifc.data_data_ok, ifc.inst_data_ok} !== 2'b10) begin
            errors++;
            $display("FAIL store_data_ok: got %b want 10",
                     {ifc.data_data_ok, ifc.inst_data_ok});
        end
        tick();
        ifc.bus_data_ok = 1'b0;
        #1;
        checks++;
        if (ifc.busy !== 1'b0) begin
            errors++;
            $display("FAIL store_idle: busy=%b want 0", ifc.busy);
        end
        tick();
        ifc.bus_addr_ok = 1'b1;
        ifc.bus_data_ok = 1'b1;
        #1;
        checks++;
        if ({ifc.bus_addr, ifc.bus_wdata} !== 64'h00001000_00000000) begin
            errors++;
            $display("FAIL inst_next_addr: got %h want 0000100000000000",
                     {ifc.bus_addr, ifc.bus_wdata});
        end
        checks++;
        if ({ifc.bus_wr, ifc.bus_size, ifc.bus_wstrb} !== 8'b0_100_0000) begin
            errors++;
            $display("FAIL inst_next_fields: got %b want 01000000",
                     {ifc.bus_wr, ifc.bus_size, ifc.bus_wstrb});
        end
        checks++;
        if ({ifc.inst_addr_ok, ifc.inst_data_ok, ifc.data_addr_ok,
             ifc.data_data_ok} !== 4'b1100) begin
            errors++;
            $display("FAIL same_cycle_oks: got %b want 1100",
                     {ifc.inst_addr_ok, ifc.inst_data_ok,
                      ifc.data_addr_ok, ifc.data_data_ok});
        end
        tick();
        ifc.inst_req    = 1'b0;
        ifc.bus_addr_ok = 1'b0;
        ifc.bus_data_ok = 1'b0;
        #1;
        checks++;
        if (ifc.busy !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_busy: got %b want 0", ifc.busy);
        end
    endtask

    task automatic test_starvation();
        logic [9:0] exp_i;
        logic       got_i;
        logic [3:0] exp_cnt;
        exp_i = 10'b10_0001_0000;
        ifc.inst_req   = 1'b1;
        ifc.inst_addr  = 32'h0000_0100;
        ifc.data_req   = 1'b1;
        ifc.data_wr    = 1'b0;
        ifc.data_size  = 3'd4;
        ifc.data_wstrb = 4'd0;
        ifc.data_addr  = 32'h0000_0200;
        ifc.data_wdata = 32'd0;
        for (int g = 0; g < 10; g++) begin
            ifc.bus_addr_ok = 1'b0;
            ifc.bus_data_ok = 1'b0;
            tick();
            got_i   = (ifc.bus_addr == 32'h0000_0100);
            exp_cnt = exp_i[g] ? 4'd0 : 4'((g % 5) + 1);
            checks++;
            if (got_i !== exp_i[g]) begin
                errors++;
                $display("FAIL grant_order[%0d]: inst=%b want %b",
                         g, got_i, exp_i[g]);
            end
            checks++;
            if (dut.r_starve_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL starve_cnt[%0d]: got %0d want %0d",
                         g, dut.r_starve_cnt, exp_cnt);
            end
            ifc.bus_addr_ok = 1'b1;
            ifc.bus_data_ok = 1'b1;
            tick();
        end
        ifc.inst_req    = 1'b0;
        ifc.data_req    = 1'b0;
        ifc.bus_addr_ok = 1'b0;
        ifc.bus_data_ok = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        ifc.inst_req  = 1'b1;
        ifc.inst_addr = 32'h0000_0700;
        ifc.data_req  = 1'b1;
        ifc.data_wr   = 1'b0;
        ifc.data_size = 3'd4;
        ifc.data_addr = 32'h0000_0300;
        tick();
        ifc.inst_req    = 1'b0;
        ifc.bus_addr_ok = 1'b1;
        #1;
        checks++;
        if (dut.r_starve_cnt !== 4'd1) begin
            errors++;
            $display("FAIL pre_reset_cnt: got %0d want 1",
                     dut.r_starve_cnt);
        end
        checks++;
        if (ifc.data_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_addr_ok: got %b want 1",
                     ifc.data_addr_ok);
        end
        tick();
        ifc.data_req    = 1'b0;
        ifc.bus_addr_ok = 1'b0;
        rst_p           = 1'b1;
        #1;
        checks++;
        if (ifc.busy !== 1'b1) begin
            errors++;
            $display("FAIL in_data_busy: got %b want 1", ifc.busy);
        end
        tick();
        rst_p           = 1'b0;
        ifc.bus_data_ok = 1'b1;
        #1;
        checks++;
        if ({ifc.busy, ifc.bus_req, ifc.data_data_ok,
             ifc.inst_data_ok} !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_stray: got %b want 0000",
                     {ifc.busy, ifc.bus_req, ifc.data_data_ok,
                      ifc.inst_data_ok});
        end
        checks++;
        if (dut.r_starve_cnt !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_cnt: got %0d want 0",
                     dut.r_starve_cnt);
        end
        tick();
        ifc.bus_data_ok = 1'b0;
        #1;
        checks++;
        if (ifc.busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b want 0", ifc.busy);
        end
    endtask

    task automatic test_stall();
        ifc.data_req   = 1'b1;
        ifc.data_wr    = 1'b1;
        ifc.data_size  = 3'd1;
        ifc.data_wstrb = 4'b0001;
        ifc.data_addr  = 32'h0000_0400;
        ifc.data_wdata = 32'h0000_0011;
        tick();
        for (int i = 0; i < 5; i++) begin
            ifc.data_addr  = 32'h0000_0500 + 32'(i);
            ifc.data_wdata = $urandom;
            ifc.data_wr    = i[0];
            ifc.data_wstrb = 4'b1111;
            ifc.inst_req   = 1'b1;
            #1;
            checks++;
            if ({ifc.bus_req, ifc.bus_wr, ifc.bus_size, ifc.bus_wstrb,
                 ifc.bus_addr, ifc.bus_wdata} !==
                {1'b1, 1'b1, 3'd1, 4'b0001, 32'h400, 32'h11}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %b %h %h",
                         i, {ifc.bus_req, ifc.bus_wr, ifc.bus_size,
                             ifc.bus_wstrb}, ifc.bus_addr,
                         ifc.bus_wdata);
            end
            checks++;
            if ({ifc.data_addr_ok, ifc.inst_addr_ok} !== 2'b00) begin
                errors++;
                $display("FAIL stall_no_ok[%0d]: got %b want 00",
                         i, {ifc.data_addr_ok, ifc.inst_addr_ok});
            end
            tick();
        end
        ifc.bus_addr_ok = 1'b1;
        #1;
        checks++;
        if ({ifc.data_addr_ok, ifc.inst_addr_ok} !== 2'b10) begin
            errors++;
            $display("FAIL stall_ack: got %b want 10",
                     {ifc.data_addr_ok, ifc.inst_addr_ok});
        end
        tick();
        ifc.data_req = 1'b0;
        ifc.inst_req = 1'b0;
        #1;
        checks++;
        if ({ifc.busy, ifc.bus_req, ifc.data_addr_ok} !== 3'b100) begin
            errors++;
            $display("FAIL data_ignores_addr_ok: got %b want 100",
                     {ifc.busy, ifc.bus_req, ifc.data_addr_ok});
        end
        tick();
        ifc.bus_addr_ok = 1'b0;
        ifc.bus_data_ok = 1'b1;
        #1;
        checks++;
        if ({ifc.busy, ifc.data_data_ok, ifc.inst_data_ok} !== 3'b110) begin
            errors++;
            $display("FAIL stall_data_ok: got %b want 110",
                     {ifc.busy, ifc.data_data_ok, ifc.inst_data_ok});
        end
        tick();
        ifc.bus_data_ok = 1'b0;
        #1;
        checks++;
        if (ifc.busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: busy=%b want 0", ifc.busy);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_p  = 1'b1;
        test_reset();
        test_inst_fetch();
        test_contention();
        test_starvation();
        test_reset_mid();
        test_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
